uart_rx_ctrl: RTL and testbench

//  Controller for the uart_rx datapath: generates its oversample_tick and buffers received bytes in a FIFO.
//  It also exposes a 4-register memory-mapped interface and an interrupt to the RISC-V core.

---
 rtl/uart_rx_ctrl_if.sv | 19 +
 rtl/uart_rx_ctrl.sv | 170 +++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_ctrl_if.sv
// Peripheral bus bundle between the SoC bus master and the uart_rx_ctrl register block.
interface uart_rx_ctrl_if;
  logic        bus_valid;
  logic        bus_we;
  logic [3:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ready;

  modport master (
    output bus_valid, bus_we, bus_addr, bus_wdata,
    input  bus_rdata, bus_ready
  );

  modport slave (
    input  bus_valid, bus_we, bus_addr, bus_wdata,
    output bus_rdata, bus_ready
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// uart_rx controller: oversample tick generator, RX byte FIFO with sticky error flags,
// four memory-mapped registers and a level interrupt.
module uart_rx_ctrl #(
  parameter int DEPTH       = 8,
  parameter int DEFAULT_DIV = 26
) (
  input  logic           clk,
  input  logic           reset,
  uart_rx_ctrl_if.slave  bus,
  output logic           oversample_tick,
  input  logic [7:0]     rx_data,
  input  logic           rx_ready,
  input  logic           framing_error,
  output logic           irq
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [8:0]    mem_q [DEPTH];
  logic [8:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   div_q, div_d, cnt_q, cnt_d;
  logic          enable_q, enable_d, irq_en_q, irq_en_d;
  logic          ovr_q, ovr_d, ferr_q, ferr_d;
  logic          rdy_q, rdy_d, tick_q, tick_d, irq_q, irq_d;
  logic          ready_q, ready_d;
  logic [31:0]   rdata_q, rdata_d;

  logic [1:0] sel_s;
  logic       accept_s, rd_acc_s, wr_acc_s, empty_s, full_s;
  logic       pop_s, push_req_s, push_s, drop_s, flush_s;
  logic       div_wr_s, status_wr_s, ctrl_wr_s;
  logic       unused_bits;

  assign unused_bits = ^{bus.bus_addr[1:0], bus.bus_wdata[31:16]};

  assign sel_s       = bus.bus_addr[3:2];
  assign accept_s    = bus.bus_valid & ~ready_q;
  assign rd_acc_s    = accept_s & ~bus.bus_we;
  assign wr_acc_s    = accept_s & bus.bus_we;
  assign empty_s     = (count_q == CW'(0));
  assign full_s      = (count_q == CW'(DEPTH));
  assign pop_s       = rd_acc_s & (sel_s == 2'd0) & ~empty_s;
  assign flush_s     = wr_acc_s & (sel_s == 2'd3) & bus.bus_wdata[2];
  assign div_wr_s    = wr_acc_s & (sel_s == 2'd2);
  assign status_wr_s = wr_acc_s & (sel_s == 2'd1);
  assign ctrl_wr_s   = wr_acc_s & (sel_s == 2'd3);
  assign push_req_s  = rx_ready & ~rdy_q & enable_q;
  // A full FIFO still accepts a push when the same cycle pops a slot free.
  assign push_s      = push_req_s & ~flush_s & (~full_s | pop_s);
  assign drop_s      = push_req_s & ~flush_s & full_s & ~pop_s;

  // Next-state computation for FIFO, registers, tick counter and bus response.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    div_d    = div_q;
    enable_d = enable_q;
    irq_en_d = irq_en_q;
    rdy_d    = rx_ready;
    ready_d  = accept_s;
    rdata_d  = 32'd0;

    if (rd_acc_s) begin
      case (sel_s)
        2'd0:    rdata_d = empty_s ? 32'd0
                         : {22'd0, mem_q[rd_ptr_q][8], 1'b1, mem_q[rd_ptr_q][7:0]};
        2'd1:    rdata_d = {16'd0, 8'(count_q), 4'd0, ovr_q, ferr_q, full_s, ~empty_s};
        2'd2:    rdata_d = {16'd0, div_q};
        2'd3:    rdata_d = {30'd0, irq_en_q, enable_q};
        default: rdata_d = 32'd0;
      endcase
    end else begin
      rdata_d = 32'd0;
    end

    if (flush_s) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_s) begin
        mem_d[wr_ptr_q] = {framing_error, rx_data};
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CW'(push_s) - CW'(pop_s);
    end

    // New error events win over a same-cycle W1C so none is lost.
    ovr_d  = (ovr_q  & ~(status_wr_s & bus.bus_wdata[3])) | drop_s;
    ferr_d = (ferr_q & ~(status_wr_s & bus.bus_wdata[2])) | (push_s & framing_error);

    if (ctrl_wr_s) begin
      enable_d = bus.bus_wdata[0];
      irq_en_d = bus.bus_wdata[1];
    end else begin
      enable_d = enable_q;
      irq_en_d = irq_en_q;
    end

    if (div_wr_s) begin
      div_d = bus.bus_wdata[15:0];
    end else begin
      div_d = div_q;
    end

    tick_d = enable_q & ~div_wr_s & (cnt_q == div_q);
    if (div_wr_s || !enable_q) begin
      cnt_d = 16'd0;
    end else if (cnt_q == div_q) begin
      cnt_d = 16'd0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end

    irq_d = irq_en_q & (~empty_s | ovr_q);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 9'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      div_q    <= 16'(DEFAULT_DIV);
      cnt_q    <= 16'd0;
      enable_q <= 1'b0;
      irq_en_q <= 1'b0;
      ovr_q    <= 1'b0;
      ferr_q   <= 1'b0;
      rdy_q    <= 1'b0;
      tick_q   <= 1'b0;
      irq_q    <= 1'b0;
      ready_q  <= 1'b0;
      rdata_q  <= 32'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      enable_q <= enable_d;
      irq_en_q <= irq_en_d;
      ovr_q    <= ovr_d;
      ferr_q   <= ferr_d;
      rdy_q    <= rdy_d;
      tick_q   <= tick_d;
      irq_q    <= irq_d;
      ready_q  <= ready_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.bus_ready   = ready_q;
  assign bus.bus_rdata   = rdata_q;
  assign oversample_tick = tick_q;
  assign irq             = irq_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: register table, directed corner sequences and random traffic,
// all checked every cycle against a queue-based reference model.
module tb_uart_rx_ctrl;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_ready, framing_error;
  logic       tick, irq;

  always #5 clk = ~clk;

  uart_rx_ctrl_if bus_if ();

  uart_rx_ctrl #(.DEPTH(DEPTH), .DEFAULT_DIV(26)) dut (
    .clk(clk), .reset(reset), .bus(bus_if),
    .oversample_tick(tick), .rx_data(rx_data), .rx_ready(rx_ready),
    .framing_error(framing_error), .irq(irq)
  );

  int n_vec = 0;
  int n_bad = 0;

  // reference model state
  logic [8:0]  m_q[$];
  bit          m_ovr = 1'b0, m_ferr = 1'b0, m_en = 1'b0, m_ien = 1'b0, m_prev_rx = 1'b0;
  int          m_div = 26, m_phase = 0;
  bit          e_ready = 1'b0, e_tick = 1'b0, e_irq = 1'b0;
  logic [31:0] e_rdata = 32'd0;

  bit rand_rx = 1'b0;
  int rx_hold = 0;

  typedef struct {
    bit          we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_eval();
    bit acc, we, pop, rise, flush, divwr;
    int sel, sz;
    logic [8:0]  head;
    logic [31:0] nrd;
    bit ntick, nirq;
    if (reset) begin
      m_q.delete();
      m_ovr = 1'b0; m_ferr = 1'b0; m_en = 1'b0; m_ien = 1'b0; m_prev_rx = 1'b0;
      m_div = 26; m_phase = 0;
      e_ready = 1'b0; e_tick = 1'b0; e_irq = 1'b0; e_rdata = 32'd0;
      return;
    end
    acc   = bus_if.bus_valid && !e_ready;
    we    = bus_if.bus_we;
    sel   = int'(bus_if.bus_addr[3:2]);
    sz    = m_q.size();
    divwr = acc && we && sel == 2;
    ntick = m_en && !divwr && ((m_phase % (m_div + 1)) == m_div);
    nirq  = m_ien && (sz != 0 || m_ovr);
    nrd   = 32'd0;
    if (acc && !we) begin
      case (sel)
        0: begin
          if (sz != 0) begin
            head = m_q[0];
            nrd  = 32'h100 | (32'(head[8]) << 9) | 32'(head[7:0]);
          end
        end
        1: nrd = (32'(sz) << 8) | (32'(m_ovr) << 3) | (32'(m_ferr) << 2)
               | (32'(sz == DEPTH) << 1) | 32'(sz != 0);
        2: nrd = 32'(m_div);
        default: nrd = (32'(m_ien) << 1) | 32'(m_en);
      endcase
    end
    pop   = acc && !we && sel == 0 && sz != 0;
    rise  = rx_ready && !m_prev_rx && m_en;
    flush = acc && we && sel == 3 && bus_if.bus_wdata[2];
    if (acc && we && sel == 1) begin
      if (bus_if.bus_wdata[3]) m_ovr = 1'b0;
      if (bus_if.bus_wdata[2]) m_ferr = 1'b0;
    end
    if (flush) begin
      m_q.delete();
    end else begin
      if (pop) void'(m_q.pop_front());
      if (rise) begin
        if (sz < DEPTH || pop) begin
          m_q.push_back({framing_error, rx_data});
          if (framing_error) m_ferr = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end
    end
    if (divwr || !m_en) m_phase = 0;
    else m_phase++;
    if (divwr) m_div = int'(bus_if.bus_wdata[15:0]);
    if (acc && we && sel == 3) begin
      m_en  = bus_if.bus_wdata[0];
      m_ien = bus_if.bus_wdata[1];
    end
    m_prev_rx = rx_ready;
    e_ready = acc; e_rdata = nrd; e_tick = ntick; e_irq = nirq;
  endtask

  task automatic gen_rx();
    if (rx_hold > 0) begin
      rx_hold--;
      rx_ready = 1'b1;
    end else if (rx_ready) begin
      rx_ready = 1'b0;
    end else if ($urandom_range(0, 5) == 0) begin
      rx_data       = 8'($urandom);
      framing_error = ($urandom_range(0, 7) == 0);
      rx_ready      = 1'b1;
      rx_hold       = $urandom_range(0, 12);
    end
  endtask

  task automatic step();
    if (rand_rx) gen_rx();
    model_eval();
    @(posedge clk);
    #1;
    chk("bus_ready", 32'(bus_if.bus_ready), 32'(e_ready));
    chk("tick", 32'(tick), 32'(e_tick));
    chk("irq", 32'(irq), 32'(e_irq));
    if (e_ready) chk("rdata", bus_if.bus_rdata, e_rdata);
  endtask

  task automatic bus(input bit we, input logic [3:0] addr, input logic [31:0] wd,
                     output logic [31:0] rd);
    bus_if.bus_valid = 1'b1;
    bus_if.bus_we    = we;
    bus_if.bus_addr  = addr;
    bus_if.bus_wdata = wd;
    step();
    rd = bus_if.bus_rdata;
    bus_if.bus_valid = 1'b0;
    step();
  endtask

  task automatic rx_byte(input logic [7:0] d, input bit fe, input int hold);
    rx_data = d; framing_error = fe; rx_ready = 1'b1;
    repeat (hold) step();
    rx_ready = 1'b0;
    step();
  endtask

  task automatic tick_window(input int n, output int c);
    c = 0;
    repeat (n) begin
      step();
      c += int'(tick);
    end
  endtask

  initial begin
    logic [31:0] rd;
    int c;
    bus_if.bus_valid = 1'b0; bus_if.bus_we = 1'b0;
    bus_if.bus_addr = 4'h0; bus_if.bus_wdata = 32'd0;
    rx_ready = 1'b0; rx_data = 8'd0; framing_error = 1'b0;
    reset = 1'b1;
    step(); step();
    chk("rst_rdata", bus_if.bus_rdata, 32'd0);
    reset = 1'b0;
    step();

    tbl[0]  = '{1'b0, 4'h4, 32'h0,         32'h0};
    tbl[1]  = '{1'b0, 4'h8, 32'h0,         32'd26};
    tbl[2]  = '{1'b0, 4'hC, 32'h0,         32'h0};
    tbl[3]  = '{1'b0, 4'h0, 32'h0,         32'h0};
    tbl[4]  = '{1'b1, 4'h8, 32'hABCD_1234, 32'h0};
    tbl[5]  = '{1'b0, 4'h8, 32'h0,         32'h0000_1234};
    tbl[6]  = '{1'b1, 4'hC, 32'hFFFF_FFFF, 32'h0};
    tbl[7]  = '{1'b0, 4'hC, 32'h0,         32'h3};
    tbl[8]  = '{1'b1, 4'hC, 32'h0,         32'h0};
    tbl[9]  = '{1'b0, 4'hC, 32'h0,         32'h0};
    tbl[10] = '{1'b1, 4'h8, 32'd26,        32'h0};
    tbl[11] = '{1'b0, 4'h8, 32'h0,         32'd26};
    for (int i = 0; i < 12; i++) begin
      bus(tbl[i].we, tbl[i].addr, tbl[i].wdata, rd);
      chk($sformatf("tbl%0d", i), rd, tbl[i].exp);
    end

    // tick generator
    bus(1'b1, 4'h8, 32'd3, rd);
    bus(1'b1, 4'hC, 32'd1, rd);
    repeat (3) step();
    tick_window(16, c); chk("tick_div3", 32'(c), 32'd4);
    bus(1'b1, 4'h8, 32'd0, rd);
    step();
    tick_window(8, c); chk("tick_div0", 32'(c), 32'd8);
    bus(1'b1, 4'hC, 32'd0, rd);
    step(); step();
    tick_window(8, c); chk("tick_off", 32'(c), 32'd0);

    // long rx_ready gives one push
    bus(1'b1, 4'hC, 32'd1, rd);
    rx_byte(8'hA5, 1'b0, 20);
    bus(1'b0, 4'h0, 32'd0, rd); chk("one_push_data", rd, 32'h1A5);
    bus(1'b0, 4'h4, 32'd0, rd); chk("one_push_status", rd, 32'h0);

    // overflow
    for (int i = 0; i < 8; i++) rx_byte(8'(i), 1'b0, 2);
    rx_byte(8'hFF, 1'b0, 2);
    bus(1'b0, 4'h4, 32'd0, rd); chk("ovf_status", rd, 32'h80B);
    for (int i = 0; i < 8; i++) begin
      bus(1'b0, 4'h0, 32'd0, rd); chk($sformatf("ovf_rd%0d", i), rd, 32'h100 + 32'(i));
    end
    bus(1'b0, 4'h4, 32'd0, rd); chk("ovf_drained", rd, 32'h8);
    bus(1'b1, 4'h4, 32'h8, rd);
    bus(1'b0, 4'h4, 32'd0, rd); chk("ovr_w1c", rd, 32'h0);

    // full FIFO: push and pop in the same cycle
    for (int i = 0; i < 8; i++) rx_byte(8'(i), 1'b0, 1);
    rx_data = 8'h55; framing_error = 1'b0; rx_ready = 1'b1;
    bus_if.bus_valid = 1'b1; bus_if.bus_we = 1'b0; bus_if.bus_addr = 4'h0;
    step();
    rd = bus_if.bus_rdata;
    chk("pushpop_data", rd, 32'h100);
    bus_if.bus_valid = 1'b0;
    step();
    rx_ready = 1'b0;
    step();
    bus(1'b0, 4'h4, 32'd0, rd); chk("pushpop_status", rd, 32'h803);
    for (int i = 0; i < 8; i++) begin
      bus(1'b0, 4'h0, 32'd0, rd);
      chk($sformatf("pushpop_rd%0d", i), rd, (i < 7) ? 32'h101 + 32'(i) : 32'h155);
    end

    // framing error
    rx_byte(8'h3C, 1'b1, 2);
    framing_error = 1'b0;
    bus(1'b0, 4'h0, 32'd0, rd); chk("ferr_data", rd, 32'h33C);
    bus(1'b0, 4'h4, 32'd0, rd); chk("ferr_status", rd, 32'h4);
    bus(1'b1, 4'h4, 32'h4, rd);
    bus(1'b0, 4'h4, 32'd0, rd); chk("ferr_w1c", rd, 32'h0);

    // interrupt and flush
    bus(1'b1, 4'hC, 32'd3, rd);
    rx_data = 8'h11; rx_ready = 1'b1;
    step(); chk("irq_lat0", 32'(irq), 32'd0);
    step(); chk("irq_set", 32'(irq), 32'd1);
    rx_ready = 1'b0;
    step();
    bus(1'b0, 4'h0, 32'd0, rd); chk("irq_data", rd, 32'h111);
    chk("irq_clr", 32'(irq), 32'd0);
    for (int i = 0; i < 3; i++) rx_byte(8'(8'h20 + i), 1'b0, 1);
    bus(1'b1, 4'hC, 32'd7, rd);
    bus(1'b0, 4'h4, 32'd0, rd); chk("flush_status", rd, 32'h0);
    bus(1'b0, 4'hC, 32'd0, rd); chk("flush_ctrl", rd, 32'h3);

    // reset mid-access drops the pending response and empties the FIFO
    rx_byte(8'h77, 1'b0, 1);
    bus_if.bus_valid = 1'b1; bus_if.bus_we = 1'b0; bus_if.bus_addr = 4'h4;
    step();
    bus_if.bus_valid = 1'b0; reset = 1'b1;
    step(); chk("rst_mid_ready", 32'(bus_if.bus_ready), 32'd0);
    reset = 1'b0;
    step();
    bus(1'b0, 4'h4, 32'd0, rd); chk("rst_mid_status", rd, 32'h0);
    bus(1'b0, 4'h8, 32'd0, rd); chk("rst_mid_div", rd, 32'd26);

    // random traffic against the model
    bus(1'b1, 4'h8, 32'd2, rd);
    bus(1'b1, 4'hC, 32'd3, rd);
    rand_rx = 1'b1;
    for (int i = 0; i < 700; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: bus(1'b0, 4'h0, 32'd0, rd);
        4, 5:       bus(1'b0, 4'h4, 32'd0, rd);
        6:          bus(1'b1, 4'h4, 32'($urandom_range(0, 15)) << 0, rd);
        7:          bus(1'b1, 4'h8, 32'($urandom_range(0, 4)), rd);
        8:          bus(1'b1, 4'hC, {29'd0, ($urandom_range(0, 9) == 0),
                                     1'($urandom), ($urandom_range(0, 7) != 0)}, rd);
        default:    bus(1'b0, {($urandom_range(0, 1) == 1), 1'b1, 2'b00}, 32'd0, rd);
      endcase
      repeat ($urandom_range(0, 3)) step();
    end
    rand_rx = 1'b0;
    rx_ready = 1'b0;
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
